// File: rtl/data_sink_checker_pkg.sv
// Shared types for data_sink_checker: FSM state encoding and error cause codes.
package data_sink_checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_DATA    = 3'd1;
  localparam logic [2:0] ERR_META    = 3'd2;
  localparam logic [2:0] ERR_OVERRUN = 3'd3;
  localparam logic [2:0] ERR_SPACING = 3'd4;

endpackage

// File: rtl/data_sink_checker_rom.sv
// Expected-word table for data_sink_checker; contents come from the packed INIT_DATA
// parameter (word i at bits [i*WIDTH +: WIDTH]) and are read combinationally by index.
module data_sink_rom #(
  parameter int WIDTH    = 32,
  parameter int N_DATA   = 8,
  parameter int LOGNDATA = 3,
  parameter logic [WIDTH*N_DATA-1:0] INIT_DATA = '0
) (
  input  logic [LOGNDATA-1:0] addr,
  output logic [WIDTH-1:0]    data
);

  localparam logic [LOGNDATA:0] N_DATA_W = (LOGNDATA+1)'(N_DATA);

  // Combinational lookup; out-of-range addresses read as zero.
  always_comb begin
    data = '0;
    if ({1'b0, addr} < N_DATA_W) begin
      data = INIT_DATA[WIDTH*int'(addr) +: WIDTH];
    end else begin
      data = '0;
    end
  end

endmodule

// File: rtl/data_sink_checker.sv
// Self-checking sink for the data_source test stream: compares each in_nd sample with the
// expected ROM word and loop-index meta. Optional inter-sample spacing check: `SPACING_CHECK_EN.
module data_sink_checker
  import data_sink_checker_pkg::*;
#(
  parameter int SENDNTH    = 3,
  parameter int LOGSENDNTH = 2,
  parameter int N_LOOPS    = 2,
  parameter int LOGNLOOPS  = 1,
  parameter int WIDTH      = 32,
  parameter int MWIDTH     = 1,
  parameter int N_DATA     = 8,
  parameter int LOGNDATA   = 3,
  parameter logic [WIDTH*N_DATA-1:0] INIT_DATA = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_nd,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [MWIDTH-1:0]    in_m,
  output logic                 done,
  output logic                 error,
  output logic [2:0]           err_code,
  output logic [LOGNDATA-1:0]  err_idx,
  output logic [LOGNLOOPS-1:0] err_loop
);

  localparam logic [LOGNDATA-1:0]  LAST_IDX  = LOGNDATA'(N_DATA - 1);
  localparam logic [LOGNLOOPS-1:0] LAST_LOOP = LOGNLOOPS'(N_LOOPS - 1);

  state_e                 state_q, state_d;
  logic [LOGNDATA-1:0]    idx_q, idx_d;
  logic [LOGNLOOPS-1:0]   loop_q, loop_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [2:0]             err_code_q, err_code_d;
  logic [LOGNDATA-1:0]    err_idx_q, err_idx_d;
  logic [LOGNLOOPS-1:0]   err_loop_q, err_loop_d;
  logic [WIDTH-1:0]       rom_data_s;
  logic [MWIDTH+LOGNLOOPS-1:0] loop_ext_s;
  logic [MWIDTH-1:0]      exp_m_s;
  logic [2:0]             code_s;
  logic                   spacing_bad_s;

  data_sink_rom #(
    .WIDTH    (WIDTH),
    .N_DATA   (N_DATA),
    .LOGNDATA (LOGNDATA),
    .INIT_DATA(INIT_DATA)
  ) u_rom (
    .addr(idx_q),
    .data(rom_data_s)
  );

  // Meta carries the loop index, zero-extended or truncated to MWIDTH.
  assign loop_ext_s = {{MWIDTH{1'b0}}, loop_q};
  assign exp_m_s    = loop_ext_s[MWIDTH-1:0];

`ifdef SPACING_CHECK_EN
  localparam logic [LOGSENDNTH-1:0] SEND_SAT = LOGSENDNTH'(SENDNTH);
  logic [LOGSENDNTH-1:0] gap_q, gap_d;

  // Cycles since the last in_nd, saturating; starts saturated so the first sample is legal.
  always_comb begin
    gap_d = gap_q;
    if (in_nd) begin
      gap_d = LOGSENDNTH'(1);
    end else if (gap_q != SEND_SAT) begin
      gap_d = gap_q + LOGSENDNTH'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // Spacing counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= SEND_SAT;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign spacing_bad_s = in_nd && (gap_q < SEND_SAT);
`else
  logic [LOGSENDNTH-1:0] spacing_unused_s;
  assign spacing_unused_s = LOGSENDNTH'(SENDNTH);
  assign spacing_bad_s    = 1'b0;
`endif

  // Next-state: sample classification, counters and first-error capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    loop_d     = loop_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    err_loop_d = err_loop_q;
    code_s     = ERR_NONE;
    case (state_q)
      ST_RUN: begin
        if (in_nd) begin
          if (in_data != rom_data_s) begin
            code_s = ERR_DATA;
          end else if (in_m != exp_m_s) begin
            code_s = ERR_META;
          end else if (spacing_bad_s) begin
            code_s = ERR_SPACING;
          end else begin
            code_s = ERR_NONE;
          end
          if (code_s != ERR_NONE) begin
            state_d    = ST_ERR;
            err_code_d = code_s;
            err_idx_d  = idx_q;
            err_loop_d = loop_q;
          end else if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (loop_q == LAST_LOOP) begin
              state_d = ST_DONE;
            end else begin
              loop_d = loop_q + LOGNLOOPS'(1);
            end
          end else begin
            idx_d = idx_q + LOGNDATA'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (in_nd) begin
          state_d    = ST_ERR;
          err_code_d = ERR_OVERRUN;
          err_idx_d  = idx_q;
          err_loop_d = loop_q;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      idx_q      <= '0;
      loop_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx_q  <= '0;
      err_loop_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      loop_q     <= loop_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
      err_loop_q <= err_loop_d;
    end
  end

  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;
  assign err_loop = err_loop_q;

endmodule

// File: tb/tb_data_sink_checker.sv
// Scoreboard bench for data_sink_checker: stimulus queues the expected outcome of each
// scenario; a negedge monitor pops and compares whenever done/error changes to an active value.
module tb_data_sink_checker;

  localparam logic [31:0] W0 = 32'hDEAD_BEEF;
  localparam logic [31:0] W1 = 32'h0000_0001;
  localparam logic [31:0] W2 = 32'hCAFE_F00D;
  localparam logic [31:0] W3 = 32'h1234_5678;
  localparam logic [31:0] W4 = 32'h8000_0000;
  localparam logic [31:0] W5 = 32'h0F0F_0F0F;
  localparam logic [31:0] W6 = 32'hFFFF_FFFF;
  localparam logic [31:0] W7 = 32'hA5A5_5A5A;
  localparam logic [255:0] INIT = {W7, W6, W5, W4, W3, W2, W1, W0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_nd = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic [0:0]  in_m = 1'b0;
  logic        done, error;
  logic [2:0]  err_code;
  logic [2:0]  err_idx;
  logic [0:0]  err_loop;

  typedef struct {
    logic       d;
    logic       e;
    logic [2:0] code;
    logic [2:0] idx;
    logic       lp;
    bit         chk_pos;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] prev_ev = 2'b00;

  data_sink_checker #(
    .SENDNTH(3), .LOGSENDNTH(2), .N_LOOPS(2), .LOGNLOOPS(1),
    .WIDTH(32), .MWIDTH(1), .N_DATA(8), .LOGNDATA(3), .INIT_DATA(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_nd(in_nd), .in_data(in_data), .in_m(in_m),
    .done(done), .error(error), .err_code(err_code), .err_idx(err_idx), .err_loop(err_loop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    case (i)
      0: word = W0;
      1: word = W1;
      2: word = W2;
      3: word = W3;
      4: word = W4;
      5: word = W5;
      6: word = W6;
      7: word = W7;
      default: word = 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per transition of {done,error} to an active value.
  always @(negedge clk) begin
    exp_t x;
    if ({done, error} != prev_ev && {done, error} != 2'b00) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got done=%0b error=%0b expected none", done, error);
      end else begin
        x = sb.pop_front();
        check("ev_done", {31'h0, done}, {31'h0, x.d});
        check("ev_error", {31'h0, error}, {31'h0, x.e});
        check("ev_code", {29'h0, err_code}, {29'h0, x.code});
        check("ev_exclusive", {31'h0, done & error}, 32'h0);
        if (x.chk_pos) begin
          check("ev_idx", {29'h0, err_idx}, {29'h0, x.idx});
          check("ev_loop", {31'h0, err_loop}, {31'h0, x.lp});
        end
      end
    end
    prev_ev = {done, error};
  end

  task automatic expect_ev(input logic d, input logic e, input logic [2:0] code,
                           input logic [2:0] idx, input logic lp, input bit pos);
    exp_t x;
    x.d = d; x.e = e; x.code = code; x.idx = idx; x.lp = lp; x.chk_pos = pos;
    sb.push_back(x);
  endtask

  task automatic send(input logic [31:0] data, input logic m, input int gap);
    in_nd = 1'b1;
    in_data = data;
    in_m = m;
    @(posedge clk);
    #1 in_nd = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    in_nd = 1'b0;
    #1;
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    check("rst_code", {29'h0, err_code}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_words(input int first, input int count, input int gap);
    for (int s = first; s < first + count; s++) begin
      send(word(s % 8), s / 8, gap);
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("init_done", {31'h0, done}, 32'h0);
    check("init_error", {31'h0, error}, 32'h0);
    check("init_idx", {29'h0, err_idx}, 32'h0);
    check("init_loop", {31'h0, err_loop}, 32'h0);
    do_reset();

    // Clean run, one sample every third cycle
    run_words(0, 15, 2);
    check("clean_not_done_early", {31'h0, done}, 32'h0);
    expect_ev(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    send(word(7), 1'b1, 0);
    check("clean_done_latency", {31'h0, done}, 32'h1);
    drain("clean");

    // Overrun after done
    repeat (2) @(posedge clk);
    expect_ev(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0);
    send(word(0), 1'b0, 0);
    check("overrun_done_drop", {31'h0, done}, 32'h0);
    drain("overrun");

    // Data fault on word 5 of loop 1
    do_reset();
    run_words(0, 13, 2);
    check("data_pre_error", {31'h0, error}, 32'h0);
    expect_ev(1'b0, 1'b1, 3'd1, 3'd5, 1'b1, 1'b1);
    send(word(5) ^ 32'h1, 1'b1, 2);
    drain("data");
    run_words(14, 2, 2);
    check("data_done_stays_low", {31'h0, done}, 32'h0);
    check("data_code_frozen", {29'h0, err_code}, 32'h1);

    // Meta fault on sample 2 of loop 0; later faults leave capture unchanged
    do_reset();
    run_words(0, 2, 2);
    expect_ev(1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 1'b1);
    send(word(2), 1'b1, 2);
    drain("meta");
    send(32'h0, 1'b0, 2);
    check("meta_code_frozen", {29'h0, err_code}, 32'h2);
    check("meta_idx_frozen", {29'h0, err_idx}, 32'h2);

    // Data and meta both wrong: data wins
    do_reset();
    expect_ev(1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 1'b1);
    send(~word(0), 1'b1, 2);
    drain("priority");

    // Back-to-back samples
    do_reset();
`ifdef SPACING_CHECK_EN
    send(word(0), 1'b0, 0);
    expect_ev(1'b0, 1'b1, 3'd4, 3'd1, 1'b0, 1'b1);
    send(word(1), 1'b0, 2);
    drain("spacing");
`else
    run_words(0, 2, 0);
    check("nospacing_no_error", {31'h0, error}, 32'h0);
    run_words(2, 13, 0);
    expect_ev(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    send(word(7), 1'b1, 0);
    drain("nospacing_done");
`endif

    // Reset mid-run, then full clean run
    do_reset();
    run_words(0, 6, 2);
    do_reset();
    run_words(0, 15, 2);
    check("rerun_not_done_early", {31'h0, done}, 32'h0);
    expect_ev(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    send(word(7), 1'b1, 2);
    drain("rerun");
    check("rerun_error_low", {31'h0, error}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
